combo_encoder: RTL and testbench
================================

# combo_encoder

Registered 8-to-3 encoder with stability filtering and a valid/ack handshake. It is the inverse of the 3-to-8 combo decoder. It watches eight combo lines (combo0..combo7), waits until a single line has been stable for a programmable number of cycles, and presents the matching {up, left, right} code to a downstream consumer. Multi-hot input patterns are flagged rather than encoded. The block sits between raw combo/button sources and the game-control logic.

## Interface

**Parameters**
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted. Legal range 2 .. 2^CNT_W-1.
- `CNT_W`, default 8: width of the stability counter.

**Ports**
- `clk`, input, 1: the block's only clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `enable`, input, 1: block enable. Low aborts any operation in progress.
- `combo0` .. `combo7`, input, 1 each: combo request lines; combo index i encodes as {up, left, right} = i.
- `ack`, input, 1: consumer accepts the presented code. Only meaningful while `valid` = 1.
- `up`, output, 1: code bit 2 (MSB).
- `left`, output, 1: code bit 1.
- `right`, output, 1: code bit 0 (LSB).
- `valid`, output, 1: the code on up/left/right is new and not yet acknowledged.
- `error`, output, 1: one-cycle pulse when a stable multi-hot pattern is detected.

## Operation

**Input sampling**
- `s[7:0]` = {combo7..combo0}, registered every edge.
- The FSM acts on `s` only, never on raw inputs.

**States**
- **IDLE**
  - enable=1 and s≠0: go to SETTLE, cand←s, cnt←1.
  - Otherwise remain in IDLE.
- **SETTLE**
  - s==0: go to IDLE.
  - s≠cand, s≠0: restart. cand←s, cnt←1.
  - s==cand, cnt<STABLE_CYCLES-1: cnt←cnt+1.
  - s==cand, cnt==STABLE_CYCLES-1, cand one-hot: load {up,left,right} with the index of the set bit, valid←1, go to PRESENT.
  - s==cand, cnt==STABLE_CYCLES-1, cand multi-hot: error←1 for one cycle, code unchanged, go to WAIT_RELEASE.
- **PRESENT**
  - valid held at 1; code held stable.
  - ack=1: valid←0, go to WAIT_RELEASE.
  - Input changes are ignored while in this state.
- **WAIT_RELEASE**
  - s==0: go to IDLE. Holding a combo therefore produces exactly one event.

**Enable and code retention**
- enable=0 in any state: next edge goes to IDLE, valid←0, error←0, cnt←0. Code bits are retained.
- up/left/right hold the last accepted code until the next accepted code. Only reset clears them.

**Reset (rst_n=0 at an edge)**
- State IDLE.
- s, cand, cnt = 0.
- up = left = right = 0, valid = 0, error = 0.
- Reset wins over every other condition, including mid-SETTLE and mid-PRESENT.

## Timing

**Latency**
- Combo line stable before edge E0 (sampled into s at E0).
- cnt=1 after E0+1.
- valid=1 and code visible after edge E0+STABLE_CYCLES.
- With the default parameter this is 4 edges after the sampling edge.

**Handshake**
- ack is sampled at each rising edge while valid=1.
- ack in the first valid cycle is legal: valid is high for exactly one cycle.
- ack while valid=0 has no effect.

**Error pulse**
- Asserted for exactly one cycle, on the same edge the pattern qualifies.
- valid stays 0 throughout.

**Return to IDLE**
- Minimum one cycle with s==0 in WAIT_RELEASE.
- A new combo can then be accepted no sooner than STABLE_CYCLES+1 edges after release is sampled.

## Test plan

All scenarios use STABLE_CYCLES = 4.

1. **Reset values.** Hold rst_n=0 for 3 edges with combo6=1 and enable=1 -> all outputs 0, FSM in IDLE. Release rst_n -> normal acceptance starts from the next sampled edge.
2. **Single accept.** enable=1, combo5=1 held, ack=0 -> valid=1 after edge E0+4 with up=1, left=0, right=1. valid stays 1 for 10 cycles. ack=1 for one cycle -> valid=0. combo5 still high -> no second event. Drop combo5, then raise combo2 -> code 010 presented after 4 more edges.
3. **Bounce filtering.** combo3 high 2 cycles, low 1, high 5 -> exactly one valid, code 011, timed from the final rising sample. A combo1→combo4 switch mid-SETTLE -> counter restarts, result code 100.
4. **Multi-hot.** combo0 and combo7 held together -> error=1 for exactly one cycle after E0+4, valid=0, code keeps previous value. No further error until both lines are released and reasserted.
5. **Enable abort.** Deassert enable during SETTLE -> no valid. Deassert enable during PRESENT -> valid=0 next edge, code retained. Reassert enable with combo held -> fresh 4-edge settle, then valid.
6. **Sweep and mid-operation reset.** Sweep combo0..combo7 one at a time with immediate ack -> codes 000..111 in order. Assert rst_n=0 while valid=1 -> valid, error and code all 0 next edge.

Source files
------------

// File: rtl/combo_encoder.sv
// -----------------------------------------------------------------------------
// combo_encoder
//
// Registered 8-to-3 encoder with stability filtering and a valid/ack handshake.
// The eight combo request lines are sampled every edge. A non-zero pattern must
// stay unchanged for STABLE_CYCLES consecutive samples before it is acted upon:
//   - one-hot pattern   -> its bit index is presented on {up,left,right} with
//                          valid held high until the consumer acks;
//   - multi-hot pattern -> a one-cycle error pulse, code left untouched.
// After either outcome the block waits for all lines to be released, so a held
// combo produces exactly one event.
//
// Parameters
//   STABLE_CYCLES : consecutive identical samples needed (2 .. 2^CNT_W-1)
//   CNT_W         : width of the stability counter
//
// Ports
//   clk            in  : clock, rising edge
//   rst_n          in  : synchronous active-low reset
//   enable         in  : block enable; low aborts anything in progress
//   combo0..combo7 in  : combo request lines, line i encodes as code i
//   ack            in  : consumer accepts the presented code (while valid)
//   up/left/right  out : code bits 2/1/0, hold the last accepted code
//   valid          out : code is new and not yet acknowledged
//   error          out : one-cycle pulse on a stable multi-hot pattern
// -----------------------------------------------------------------------------
module combo_encoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic combo0,
    input  logic combo1,
    input  logic combo2,
    input  logic combo3,
    input  logic combo4,
    input  logic combo5,
    input  logic combo6,
    input  logic combo7,
    input  logic ack,
    output logic up,
    output logic left,
    output logic right,
    output logic valid,
    output logic error
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT,
        WAIT_RELEASE
    } state_t;

    // Counter value at which the current sample is the last one needed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Index of the highest set bit; only used on one-hot values.
    function automatic logic [2:0] bit_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [7:0]       s;
    logic [7:0]       cand;
    logic [7:0]       cand_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       code;
    logic [2:0]       code_next;
    logic             valid_next;
    logic             error_next;

    // ---- input sampling stage: the FSM only ever looks at s ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s <= 8'd0;
        end else begin
            s <= {combo7, combo6, combo5, combo4, combo3, combo2, combo1, combo0};
        end
    end

    // ---- control stage: state and registered outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= 8'd0;
            cnt   <= '0;
            code  <= 3'd0;
            valid <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
            code  <= code_next;
            valid <= valid_next;
            error <= error_next;
        end
    end

    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        code_next  = code;
        valid_next = valid;
        error_next = 1'b0;

        if (!enable) begin
            // Abort: code bits are deliberately left alone.
            state_next = IDLE;
            valid_next = 1'b0;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s != 8'd0) begin
                        state_next = SETTLE;
                        cand_next  = s;
                        cnt_next   = CNT_ONE;
                    end
                end

                SETTLE: begin
                    if (s == 8'd0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (s != cand) begin
                        // Pattern moved: start counting the new one from scratch.
                        cand_next = s;
                        cnt_next  = CNT_ONE;
                    end else if (cnt < CNT_LAST) begin
                        cnt_next = cnt + CNT_ONE;
                    end else if (is_one_hot(cand)) begin
                        code_next  = bit_index(cand);
                        valid_next = 1'b1;
                        cnt_next   = '0;
                        state_next = PRESENT;
                    end else begin
                        error_next = 1'b1;
                        cnt_next   = '0;
                        state_next = WAIT_RELEASE;
                    end
                end

                PRESENT: begin
                    // Inputs are ignored until the consumer takes the code.
                    if (ack) begin
                        valid_next = 1'b0;
                        state_next = WAIT_RELEASE;
                    end
                end

                WAIT_RELEASE: begin
                    if (s == 8'd0) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign up    = code[2];
    assign left  = code[1];
    assign right = code[0];

endmodule

// File: tb/tb_combo_encoder.sv
module tb_combo_encoder;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] cv;
    logic       ack;
    logic       up, left, right, valid, error;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    combo_encoder #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .combo0 (cv[0]),
        .combo1 (cv[1]),
        .combo2 (cv[2]),
        .combo3 (cv[3]),
        .combo4 (cv[4]),
        .combo5 (cv[5]),
        .combo6 (cv[6]),
        .combo7 (cv[7]),
        .ack    (ack),
        .up     (up),
        .left   (left),
        .right  (right),
        .valid  (valid),
        .error  (error)
    );

    // Directed vectors: inputs applied for one edge, then {up,left,right,valid,error}.
    typedef struct {
        string      name;
        logic       r;
        logic       e;
        logic [7:0] c;
        logic       a;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic e,
                       input logic [7:0] c, input logic a, input logic [4:0] exp,
                       input int n);
        vec_t v;
        v.name = name; v.r = r; v.e = e; v.c = c; v.a = a; v.exp = exp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Reference model: a pattern is accepted once the last SC samples seen
    // while hunting are all the same non-zero value. Phases: hunting, holding
    // a presented code, waiting for the lines to be released.
    localparam int HUNT = 0, HOLD = 1, RELEASE = 2;
    int         m_phase = HUNT;
    logic [7:0] m_s     = 8'd0;
    logic [7:0] hist[$];
    logic [2:0] m_code  = 3'd0;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;

    task automatic model_step(input logic r, input logic e,
                              input logic [7:0] c, input logic a);
        logic [7:0] p;
        bit         same;
        if (!r) begin
            m_s = 8'd0; hist.delete(); m_code = 3'd0;
            m_valid = 1'b0; m_err = 1'b0; m_phase = HUNT;
            return;
        end
        p     = m_s;
        m_err = 1'b0;
        if (!e) begin
            m_phase = HUNT; hist.delete(); m_valid = 1'b0;
        end else if (m_phase == HUNT) begin
            if (p == 8'd0) begin
                hist.delete();
            end else begin
                hist.push_back(p);
                if (hist.size() > SC) void'(hist.pop_front());
                same = (hist.size() == SC);
                foreach (hist[k]) if (hist[k] != p) same = 1'b0;
                if (same) begin
                    hist.delete();
                    if ($countones(p) == 1) begin
                        m_code  = 3'($clog2(p));
                        m_valid = 1'b1;
                        m_phase = HOLD;
                    end else begin
                        m_err   = 1'b1;
                        m_phase = RELEASE;
                    end
                end
            end
        end else if (m_phase == HOLD) begin
            if (a) begin
                m_valid = 1'b0; m_phase = RELEASE;
            end
        end else begin
            if (p == 8'd0) m_phase = HUNT;
        end
        m_s = c;
    endtask

    task automatic apply(input logic r, input logic e, input logic [7:0] c, input logic a);
        @(negedge clk);
        rst_n = r; enable = e; cv = c; ack = a;
        @(posedge clk);
        model_step(r, e, c, a);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got ulrve=%b expected %b at %0t", name, act, exp, $time);
    endtask

    initial begin
        logic [2:0] prev;
        logic [7:0] pat;
        int         hold;
        int         sel;
        logic       rr, en, a;

        rst_n = 1'b0; enable = 1'b1; cv = 8'd0; ack = 1'b0;

        // Reset held with combo6 up, then normal acceptance.
        add("reset_hold",    0, 1, 8'h40, 0, 5'b00000, 3);
        add("reset_release", 1, 1, 8'h40, 0, 5'b00000, 4);
        add("accept6",       1, 1, 8'h40, 0, 5'b11010, 1);
        add("ack6",          1, 1, 8'h40, 1, 5'b11000, 1);
        add("release6",      1, 1, 8'h00, 0, 5'b11000, 2);
        // Single accept with a long wait for ack, no repeat while held.
        add("settle5",       1, 1, 8'h20, 0, 5'b11000, 4);
        add("present5",      1, 1, 8'h20, 0, 5'b10110, 10);
        add("ack5",          1, 1, 8'h20, 1, 5'b10100, 1);
        add("held5",         1, 1, 8'h20, 0, 5'b10100, 3);
        add("release5",      1, 1, 8'h00, 0, 5'b10100, 2);
        add("settle2",       1, 1, 8'h04, 0, 5'b10100, 4);
        add("accept2",       1, 1, 8'h04, 0, 5'b01010, 1);
        add("ack2",          1, 1, 8'h00, 1, 5'b01000, 1);
        add("release2",      1, 1, 8'h00, 0, 5'b01000, 1);
        // Bounce on combo3: 2 high, 1 low, 5 high.
        add("bounce_hi",     1, 1, 8'h08, 0, 5'b01000, 2);
        add("bounce_lo",     1, 1, 8'h00, 0, 5'b01000, 1);
        add("bounce_settle", 1, 1, 8'h08, 0, 5'b01000, 4);
        add("bounce_accept", 1, 1, 8'h08, 0, 5'b01110, 1);
        add("bounce_ack",    1, 1, 8'h00, 1, 5'b01100, 1);
        add("bounce_rel",    1, 1, 8'h00, 0, 5'b01100, 1);
        // combo1 -> combo4 switch mid-settle.
        add("switch_1",      1, 1, 8'h02, 0, 5'b01100, 2);
        add("switch_4",      1, 1, 8'h10, 0, 5'b01100, 4);
        add("switch_accept", 1, 1, 8'h10, 0, 5'b10010, 1);
        add("switch_ack",    1, 1, 8'h00, 1, 5'b10000, 1);
        add("switch_rel",    1, 1, 8'h00, 0, 5'b10000, 1);
        // Multi-hot combo0+combo7.
        add("multi_settle",  1, 1, 8'h81, 0, 5'b10000, 4);
        add("multi_err",     1, 1, 8'h81, 0, 5'b10001, 1);
        add("multi_held",    1, 1, 8'h81, 1, 5'b10000, 3);
        add("multi_rel",     1, 1, 8'h00, 0, 5'b10000, 2);
        add("multi_again",   1, 1, 8'h81, 0, 5'b10000, 4);
        add("multi_err2",    1, 1, 8'h81, 0, 5'b10001, 1);
        add("multi_rel2",    1, 1, 8'h00, 0, 5'b10000, 2);
        // Enable abort during settle and during present.
        add("en_settle",     1, 1, 8'h02, 0, 5'b10000, 2);
        add("en_abort_s",    1, 0, 8'h02, 0, 5'b10000, 4);
        add("en_resettle",   1, 1, 8'h02, 0, 5'b10000, 3);
        add("en_accept",     1, 1, 8'h02, 0, 5'b00110, 1);
        add("en_abort_p",    1, 0, 8'h02, 0, 5'b00100, 2);
        add("en_resettle2",  1, 1, 8'h02, 0, 5'b00100, 3);
        add("en_accept2",    1, 1, 8'h02, 0, 5'b00110, 1);
        add("en_ack",        1, 1, 8'h00, 1, 5'b00100, 1);
        add("en_rel",        1, 1, 8'h00, 0, 5'b00100, 1);
        // Sweep with ack held high throughout.
        prev = 3'b001;
        for (int i = 0; i < 8; i++) begin
            add("sweep_settle", 1, 1, 8'(1 << i), 1, {prev, 2'b00}, 4);
            add("sweep_accept", 1, 1, 8'(1 << i), 1, {3'(i), 2'b10}, 1);
            add("sweep_ack",    1, 1, 8'h00,      1, {3'(i), 2'b00}, 2);
            prev = 3'(i);
        end
        // Reset while presenting, and reset mid-settle.
        add("rst_settle",    1, 1, 8'h40, 0, 5'b11100, 4);
        add("rst_present",   1, 1, 8'h40, 0, 5'b11010, 1);
        add("rst_mid_pres",  0, 1, 8'h40, 0, 5'b00000, 1);
        add("rst_after",     1, 1, 8'h00, 0, 5'b00000, 2);
        add("rst_s_pre",     1, 1, 8'h08, 0, 5'b00000, 2);
        add("rst_mid_set",   0, 1, 8'h08, 0, 5'b00000, 1);
        add("rst_s_settle",  1, 1, 8'h08, 0, 5'b00000, 4);
        add("rst_s_accept",  1, 1, 8'h08, 0, 5'b01110, 1);
        add("rst_s_ack",     1, 1, 8'h00, 1, 5'b01100, 1);
        add("rst_s_rel",     1, 1, 8'h00, 0, 5'b01100, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].a);
            check(vecs[i].name, {up, left, right, valid, error}, vecs[i].exp);
        end

        // Randomized run against the reference model.
        apply(1'b0, 1'b1, 8'h00, 1'b0);
        check("rand_reset", {up, left, right, valid, error}, {m_code, m_valid, m_err});
        hold = 0;
        pat  = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 3)      pat = 8'h00;
                else if (sel < 8) pat = 8'(1 << $urandom_range(0, 7));
                else              pat = 8'($urandom_range(1, 255));
                hold = $urandom_range(1, 9);
            end
            hold--;
            rr = ($urandom_range(0, 199) != 0);
            en = ($urandom_range(0, 31) != 0);
            a  = ($urandom_range(0, 3) == 0);
            apply(rr, en, pat, a);
            check("random", {up, left, right, valid, error}, {m_code, m_valid, m_err});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
